// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU definitions.
//               - Operation encodings for the 2-bit op field.
//               - State type for the sequential slice adder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_ADC = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_SBB = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
// Ports       : a, b, cin -> s (sum bit), cout (carry out)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : slice_adder
// Description : Combinational SLICE-bit ripple-carry adder built from a
//               chain of full_adder cells.
// Ports       : a, b [SLICE-1:0], cin -> sum [SLICE-1:0], cout
// Revision    : 1.0 - initial release
// ============================================================================
module slice_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  logic [SLICE:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
      full_adder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (w_carry[i]),
        .s    (sum[i]),
        .cout (w_carry[i+1])
      );
    end
  endgenerate

  assign cout = w_carry[SLICE];

endmodule
`default_nettype wire

// File: rtl/seq_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : seq_slice_adder
// Description : Multi-cycle adder/subtractor. Adds one SLICE-bit slice per
//               cycle with the carry held in a register between slices.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, op, a, b, cin   - operation input
//               out_valid/out_ready, sum, c_flag,
//               v_flag, z_flag                     - result output
// Revision    : 1.0 - initial release
// ============================================================================
module seq_slice_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_flag,
  output logic             v_flag,
  output logic             z_flag
);

  localparam int NSLICE = WIDTH / SLICE;
  // Keep the index at least one bit wide so NSLICE=1 still elaborates.
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NSLICE - 1);

  seq_state_t r_state, w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // b already inverted for subtraction
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_c, r_v, r_z;

  logic [SLICE-1:0] w_a_slice, w_b_slice, w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic             w_is_sub;
  logic             w_carry_init;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  assign w_last = (r_idx == C_LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = RUN;
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  assign w_is_sub = (op == OP_SUB) || (op == OP_SBB);

  always_comb begin
    w_carry_init = 1'b0;
    case (op)
      OP_ADD:  w_carry_init = 1'b0;
      OP_ADC:  w_carry_init = cin;
      OP_SUB:  w_carry_init = 1'b1;
      OP_SBB:  w_carry_init = cin;
      default: w_carry_init = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slice select and merge: a single slice adder serves every index.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_a_slice  = '0;
    w_b_slice  = '0;
    w_sum_next = r_sum;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_a_slice                    = r_a[i*SLICE +: SLICE];
        w_b_slice                    = r_b[i*SLICE +: SLICE];
        w_sum_next[i*SLICE +: SLICE] = w_slice_sum;
      end
    end
  end

  slice_adder #(.SLICE(SLICE)) u_slice (
    .a    (w_a_slice),
    .b    (w_b_slice),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_is_sub ? ~b : b;
            r_carry <= w_carry_init;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_c <= w_slice_cout;
            r_v <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                   (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
            r_z <= (w_sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum    = r_sum;
  assign c_flag = r_c;
  assign v_flag = r_v;
  assign z_flag = r_z;

endmodule
`default_nettype wire

// File: tb/tb_seq_slice_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_slice_adder
// Description : Directed self-checking bench for seq_slice_adder
//               (WIDTH=16, SLICE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_slice_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_flag, v_flag, z_flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_slice_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_flag    (c_flag),
    .v_flag    (v_flag),
    .z_flag    (z_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid, counting edges since the accept edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; out_ready held high.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ci, input logic [15:0] esum,
                        input logic ec, input logic ev, input logic ez);
    int cyc;
    in_valid = 1'b1; op = o; a = ta; b = tb_; cin = ci; out_ready = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; the result must not change.
    in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A; op = ~o; cin = ~ci;
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_c"}, c_flag, ec);
    chk({tag, "_v"}, v_flag, ev);
    chk({tag, "_z"}, z_flag, ez);
    chk({tag, "_inrdy_done"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, "_inrdy_after"}, in_ready, 1);
    chk({tag, "_outv_after"}, out_valid, 0);
  endtask

  initial begin
    int          cyc;
    logic [15:0] held_sum;
    logic [2:0]  held_flags;

    rst = 1'b1; in_valid = 1'b0; op = 2'd0; a = '0; b = '0; cin = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {c_flag, v_flag, z_flag}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_basic", 2'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0);
    run_op("add_ovf",   2'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0);
    run_op("sub_zero",  2'd2, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1, 0, 1);
    run_op("sub_borrow",2'd2, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 0, 0, 0);
    run_op("adc_wrap",  2'd1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1);
    run_op("sbb_ovf",   2'd3, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1, 1, 0);

    // Back-pressure: hold DONE, present a competing request meanwhile.
    in_valid = 1'b1; op = 2'd0; a = 16'h1000; b = 16'h0234; cin = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    chk("bp_latency", cyc, 4);
    chk("bp_sum", sum, 16'h1234);
    held_sum   = sum;
    held_flags = {c_flag, v_flag, z_flag};
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_sum", sum, held_sum);
      chk("bp_hold_flags", {c_flag, v_flag, z_flag}, held_flags);
      chk("bp_hold_inrdy", in_ready, 0);
      chk("bp_hold_outv", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;              // DONE -> IDLE
    chk("bp_release_inrdy", in_ready, 1);
    @(posedge clk); #1;              // pending request accepted here
    chk("bp_pending_accept", in_ready, 0);
    in_valid = 1'b0;
    wait_done(cyc);
    chk("bp_pending_latency", cyc, 4);
    chk("bp_pending_sum", sum, 16'h0003);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN with idx=2 (partial sum 0x00FF visible).
    in_valid = 1'b1; op = 2'd0; a = 16'hFFFF; b = 16'h0000; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_run_partial", sum, 16'h00FF);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_inrdy", in_ready, 1);
    chk("async_rst_outv", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("add_after_rst", 2'd0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
